// File: rtl/lsu_reg_master.sv
// Converts LSU load/store requests into single-cycle register-bus transactions.
// It handles lane steering, byte enables, load extension, window decode and misalignment faults.
module lsu_reg_master #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  bus_addr,
  output logic [3:0]  bus_wben,
  output logic        bus_r_wn,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a posedge with req_valid & req_ready;
  // a response transfers on a posedge with rsp_valid & rsp_ready, and
  // rsp_valid/rsp_rdata/rsp_err hold steady until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        lat_store;

  logic        req_err;
  logic [3:0]  req_wben;
  logic [31:0] req_bwdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    req_err = 1'b0;
    if (req_addr[31:6] != BASE_ADDR[31:6]) req_err = 1'b1;
    case (req_size)
      2'b00: ;
      2'b01: if (req_addr[0]) req_err = 1'b1;
      2'b10: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the enables alone select the bytes.
  always_comb begin
    req_wben   = 4'b0000;
    req_bwdata = 32'h0;
    case (req_size)
      2'b00: begin
        req_wben   = 4'b0001 << req_addr[1:0];
        req_bwdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_wben   = req_addr[1] ? 4'b1100 : 4'b0011;
        req_bwdata = {2{req_wdata[15:0]}};
      end
      default: begin
        req_wben   = 4'b1111;
        req_bwdata = req_wdata;
      end
    endcase
  end

  assign shifted = bus_rdata >> {lat_off, 3'b000};

  always_comb begin
    load_data = bus_rdata;
    case (lat_size)
      2'b00: load_data = lat_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = lat_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_err      <= 1'b0;
      bus_addr     <= 4'h0;
      bus_wben     <= 4'h0;
      bus_r_wn     <= 1'b1;
      bus_wdata    <= 32'h0;
      lat_off      <= 2'b00;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_store    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_off      <= req_addr[1:0];
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_store    <= req_we;
            req_ready    <= 1'b0;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state    <= ACCESS;
              bus_addr <= req_addr[5:2];
              bus_r_wn <= ~req_we;
              if (req_we) begin
                bus_wben  <= req_wben;
                bus_wdata <= req_bwdata;
              end
            end
          end
        end
        ACCESS: begin
          state     <= RESP;
          bus_addr  <= 4'h0;
          bus_wben  <= 4'h0;
          bus_r_wn  <= 1'b1;
          bus_wdata <= 32'h0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= lat_store ? 32'h0 : load_data;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_reg_master.sv
// Bench for lsu_reg_master: a byte-enabled register-block model on the bus side,
// directed test-plan requests, reset cases and random traffic scored against a queue.
module tb_lsu_reg_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [40:0] BUS_IDLE = {4'h0, 4'h0, 1'b1, 32'h0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  bus_addr;
  logic [3:0]  bus_wben;
  logic        bus_r_wn;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  logic [31:0] regs [16];
  logic [32:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  lsu_reg_master #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_wben(bus_wben), .bus_r_wn(bus_r_wn),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // clock / reset / register block
  always #5 clk = ~clk;

  assign bus_rdata = regs[bus_addr];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
    end else if (!bus_r_wn) begin
      for (int b = 0; b < 4; b++)
        if (bus_wben[b]) regs[bus_addr][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] bus_now();
    return {bus_addr, bus_wben, bus_r_wn, bus_wdata};
  endfunction

  // driver: one request, full response check; called at #1 after a posedge
  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] wd, input int hold);
    logic        e;
    logic [31:0] word, sh, exp_rd, exp_wd;
    logic [3:0]  exp_wben;
    logic [32:0] exp, snap;
    int          waited;
    e = (a[31:6] != BASE[31:6]) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
        (sz == 2'b10 && a[1:0] != 2'b00);
    word = regs[a[5:2]];
    sh = word >> (8 * a[1:0]);
    exp_rd = 32'h0;
    if (!e && !we) begin
      if (sz == 2'b00) exp_rd = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      else if (sz == 2'b01) exp_rd = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      else exp_rd = word;
    end
    exp_wben = 4'hF;
    exp_wd = wd;
    if (sz == 2'b00) begin
      exp_wben = 4'b0001 << a[1:0];
      exp_wd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    end else if (sz == 2'b01) begin
      exp_wben = a[1] ? 4'b1100 : 4'b0011;
      exp_wd = {wd[15:0], wd[15:0]};
    end
    exp_q.push_back({e, exp_rd});

    req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(posedge clk); #1; waited++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", req_ready, 1);
      req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom_range(0, 1));
    if (e) begin
      chk("err_bus_idle", bus_now(), BUS_IDLE);
      chk("err_rsp_valid", rsp_valid, 1);
    end else begin
      chk("access_bus", bus_now(), we ? {a[5:2], exp_wben, 1'b0, exp_wd}
                                      : {a[5:2], 4'h0, 1'b1, 32'h0});
      chk("access_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
    end
    snap = {rsp_err, rsp_rdata};
    for (int h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_stable", {rsp_err, rsp_rdata}, snap);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_bus_idle", bus_now(), BUS_IDLE);
      @(posedge clk); #1;
    end
    // scoreboard: pop and compare on the response transfer
    chk("rsp_valid", rsp_valid, 1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("rsp_err_rdata", {rsp_err, rsp_rdata}, exp);
    end else begin
      chk("scoreboard_empty", 1, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  // reset while a word store sits in ACCESS (stage 0) or RESP (stage 1)
  task automatic reset_in(input int stage);
    req_addr = BASE + 32'h4; req_we = 1'b1; req_size = 2'b10; req_wdata = $urandom;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_pre_state", dbg_state, 1);
    if (stage == 1) begin
      @(posedge clk); #1;
      chk("rst_pre_state", dbg_state, 2);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_bus_idle", bus_now(), BUS_IDLE);
    chk("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid_after", rsp_valid, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
    chk("reset_bus_idle", bus_now(), BUS_IDLE);
    chk("reset_state", dbg_state, 0);

    do_req(BASE + 32'h00, 1'b1, 2'b10, 1'b0, 32'h4852_4A44, 0);
    do_req(BASE + 32'h00, 1'b0, 2'b10, 1'b0, 32'h0, 0);
    do_req(BASE + 32'h1A, 1'b1, 2'b00, 1'b0, 32'h0000_00A5, 0);
    do_req(BASE + 32'h1A, 1'b0, 2'b00, 1'b0, 32'h0, 0);
    do_req(BASE + 32'h1A, 1'b0, 2'b00, 1'b1, 32'h0, 1);
    do_req(BASE + 32'h16, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 0);
    do_req(BASE + 32'h16, 1'b0, 2'b01, 1'b0, 32'h0, 0);
    do_req(BASE + 32'h14, 1'b1, 2'b10, 1'b0, 32'h8001_0000, 0);
    do_req(BASE + 32'h16, 1'b0, 2'b01, 1'b0, 32'h0, 0);
    do_req(BASE + 32'h16, 1'b0, 2'b01, 1'b1, 32'h0, 0);
    do_req(BASE + 32'h01, 1'b0, 2'b01, 1'b0, 32'h0, 0);
    do_req(BASE + 32'h06, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
    do_req(BASE + 32'h40, 1'b0, 2'b10, 1'b0, 32'h0, 0);
    do_req(BASE + 32'h00, 1'b0, 2'b11, 1'b0, 32'h0, 2);
    do_req(BASE + 32'h00, 1'b0, 2'b10, 1'b0, 32'h0, 5);
    do_req(BASE + 32'h3F, 1'b0, 2'b00, 1'b0, 32'h0, 0);

    reset_in(0);
    reset_in(1);
    do_req(BASE + 32'h04, 1'b0, 2'b10, 1'b0, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = BASE | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(6, 31));
      do_req(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_reg_master.md
# lsu_reg_master

Bus initiator that converts RISC-V load/store unit requests (byte, halfword and word, signed or unsigned) into single-cycle transactions on the peripheral register bus. It drives the bus's `addr[5:2]`, `wben`, `r_wn` and `wdata` signals and samples `rdata`. It sits between the core's LSU and the peripheral register block. It handles lane steering, byte-enable generation, load sign/zero extension, address-window decode and misalignment errors.

## Interface
Parameters:
- BASE_ADDR, 32'h4000_0000, byte base of the 64-byte register window; bits [5:0] ignored.

Ports:
- clk  in  1  master clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  LSU request valid
- req_ready  out  1  request accepted when valid&ready at posedge
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  LSU accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  1 = access faulted, no bus cycle issued
- bus_addr  out  4  register word index (byte address [5:2])
- bus_wben  out  4  write byte enables
- bus_r_wn  out  1  1 = read/idle, 0 = write
- bus_wdata  out  32  lane-replicated write data
- bus_rdata  in  32  combinational read data from register block

## Operation
- FSM has three states: IDLE, ACCESS, RESP. req_ready = (state == IDLE). All outputs are registered.
- IDLE: on req_valid, latch the request and decode it.
  - Error if req_size == 11.
  - Error if half and addr[0] != 0.
  - Error if word and addr[1:0] != 0.
  - Error if req_addr[31:6] != BASE_ADDR[31:6].
  - On error, go to RESP with rsp_err = 1 and rsp_rdata = 0. No bus cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS lasts exactly one cycle. bus_addr = addr[5:2].
  - Store, byte: bus_r_wn = 0, bus_wben = 4'b0001 << addr[1:0], bus_wdata = {4{wdata[7:0]}}.
  - Store, half: bus_r_wn = 0, bus_wben = addr[1] ? 4'b1100 : 4'b0011, bus_wdata = {2{wdata[15:0]}}.
  - Store, word: bus_r_wn = 0, bus_wben = 4'b1111, bus_wdata = wdata.
  - Load: bus_r_wn = 1, bus_wben = 0. bus_rdata is sampled at the end of the cycle and shifted right by 8*addr[1:0].
    - Byte loads take bits [7:0]; half loads take bits [15:0].
    - The result is sign- or zero-extended per req_unsigned. Word loads pass through unchanged; req_unsigned is ignored.
  - Then go to RESP.
- RESP: rsp_valid = 1, with rsp_rdata and rsp_err stable. On rsp_ready, go to IDLE and clear rsp_valid.
- Bus idle value, driven in every state except ACCESS: bus_addr = 0, bus_wben = 0, bus_r_wn = 1, bus_wdata = 0. A write strobe therefore exists only in ACCESS.
- Stores to read-only or unmapped word indices are still issued on the bus. The register block ignores them, and rsp_err = 0.

## Timing
- Reset values: state = IDLE, req_ready = 1 (the cycle after reset deasserts), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, bus outputs at idle value.
- Good access, request accepted at edge N:
  - Bus signals valid during cycle N+1.
  - rsp_valid high from edge N+2.
- Error, request accepted at edge N: rsp_valid high from edge N+1.
- With rsp_ready held high, good accesses complete one every 3 cycles and errors one every 2. IDLE is always re-entered before the next accept; a request is never accepted in the same cycle a response completes.
- Backpressure: rsp_valid, rsp_rdata and rsp_err stay constant while rsp_ready = 0. The bus stays idle.
- Reset mid-operation, in any state: on the next edge, go to IDLE and drop any pending response. The bus returns to its idle value. A write in flight on the same edge as reset is irrelevant, because the register block also resets.
- req_* inputs are don't-care outside IDLE.

## Test plan
- Word load 0x4000_0000 with register rdata = 0x48524A44 → bus_addr = 0, bus_r_wn = 1 during ACCESS; rsp_rdata = 0x48524A44, rsp_err = 0, rsp_valid 2 cycles after accept.
- Byte store 0x4000_001A, wdata = 0x000000A5 → ACCESS shows bus_addr = 6, bus_wben = 4'b0100, bus_wdata = 0xA5A5A5A5, bus_r_wn = 0. Then:
  - Signed byte load from the same address → rsp_rdata = 0xFFFFFFA5.
  - Unsigned byte load from the same address → rsp_rdata = 0x000000A5.
- Half store 0x4000_0016, wdata = 0x1234 → bus_wben = 4'b1100, bus_wdata = 0x12341234. Signed half load 0x4000_0016 with rdata = 0x8001_0000 → rsp_rdata = 0xFFFF8001.
- Error cases; each must show no bus cycle (bus_r_wn stays 1, bus_wben stays 0) and rsp_err = 1 one cycle after accept:
  - Half load 0x4000_0001.
  - Word store 0x4000_0006.
  - Word load 0x4000_0040.
  - req_size = 11.
- Backpressure: hold rsp_ray low for 5 cycles → rsp_valid and rsp_rdata stable, req_ready = 0, bus idle. Raise rsp_ready → IDLE next edge, and a new request is accepted one edge later.
- Assert reset during ACCESS of a store and separately during RESP → next cycle: rsp_valid = 0, bus outputs at idle value; req_ready = 1 after reset deasserts.
